nmr_buffer_reader: RTL and testbench
====================================

# nmr_buffer_reader

Read-out engine for the NMR acquisition path. Once an acquisition completes, it reads the captured samples back out of the sample BRAM (the memory the acquisition writer fills) and streams them as an AXI4-Stream packet towards the DMA/PS. Backpressure is honoured without losing or duplicating samples. It runs in the same clock domain as the acquisition sequencer and is started by that sequencer's done indication.

## Interface
- ADDR_WIDTH, 16: BRAM address width; the buffer holds 2^ADDR_WIDTH samples.
- DATA_WIDTH, 32: sample/stream word width.
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to read a buffer out; ignored unless in IDLE.
- nb_of_sample  input  32  samples to stream; latched on accepted start.
- bram_en  output  1  BRAM read enable.
- bram_addr  output  ADDR_WIDTH  BRAM read address.
- bram_rdata  input  DATA_WIDTH  BRAM read data, valid exactly 1 cycle after bram_en/bram_addr are presented.
- m_axis_tdata  output  DATA_WIDTH  stream data.
- m_axis_tvalid  output  1  stream valid.
- m_axis_tready  input  1  stream ready.
- m_axis_tlast  output  1  high on the final beat of the packet.
- busy  output  1  high from accepted start until done.
- done  output  1  one-cycle pulse when the packet has fully completed.
- clamped  output  1  sticky flag: the last request exceeded the buffer size; cleared on the next accepted start.
- words_sent  output  32  handshakes completed in the current or last packet.

## Operation
- Reset: every output is 0, the FSM is in IDLE, the FIFO is empty and the in-flight count is 0. This applies both at power-up and mid-packet; tvalid drops in the cycle after rst is sampled.
- States and transitions:
  - IDLE: start && N>0 → READ. start && N==0 → DONE.
  - READ: the last address has been issued → DRAIN.
  - DRAIN: the FIFO is empty and no reads are in flight → DONE.
  - DONE: → IDLE, with done=1 for exactly one cycle.
- Length:
  - N = nb_of_sample, latched on accepted start.
  - If N > 2^ADDR_WIDTH, N is clamped to 2^ADDR_WIDTH and clamped is set.
  - The address counter is ADDR_WIDTH+1 bits so it never wraps.
- Issue rule: in READ, a read is issued (bram_en=1, address incrementing from 0) only when fifo_count + in_flight < 4. This guarantees the FIFO never overflows.
- Capture: bram_rdata is written into the FIFO 1 cycle after issue; the FIFO is depth 4.
- Stream: tvalid = FIFO not empty. tdata and tlast are held stable while tvalid && !tready.
- tlast: asserted when the FIFO head is sample index N-1. For N==1 the only beat carries tlast.
- words_sent: increments on every tvalid && tready; cleared on accepted start.
- start while busy: ignored, with no effect on the current packet.
- Simultaneous FIFO push and pop in one cycle: the count is unchanged and both operations take effect.

## Timing
- Start sampled at clock edge E0:
  - E1: bram_en=1, bram_addr=0, busy=1.
  - E2: rdata captured into the FIFO.
  - After E2: tvalid=1.
- With tready held high: one beat per cycle, no bubbles. Beat k handshakes at edge E(3+k).
- done is high during the cycle after the final handshake; busy falls at the same edge.
- N==0: done in the cycle after E1 (IDLE → DONE → IDLE); no beats; tvalid never asserted.
- Backpressure: at most 4 samples are buffered. Issue stalls within 1 cycle of the credit running out, and no sample is dropped or repeated.

## Structure
- Shared package nmr_pkg holds:
  - the state encoding (IDLE, READ, DRAIN, DONE);
  - the FIFO depth constant (4);
  - the credit threshold.
- One sub-module, nmr_stream_fifo: a 4-deep synchronous FIFO with count output and first-word-fall-through head. The FSM, address counter and credit logic stay in the top module.

## Test plan
- BRAM preloaded with data = address; N=8; tready=1 → 8 beats with tdata 0..7 on consecutive cycles, tlast only on 7, words_sent=8, one done pulse.
- N=16 with tready toggling 1,0,0,1 repeating → tdata 0..15 in order, no gaps or duplicates, data held stable while stalled, FIFO count never exceeds 4.
- N=0 → no tvalid at all, done asserted 2 cycles after start.
- N=2^ADDR_WIDTH+5 → clamped=1, exactly 2^ADDR_WIDTH beats, addresses never wrap, tlast on address 2^ADDR_WIDTH-1.
- rst asserted after beat 3 of N=10 → outputs 0 next cycle; a fresh start with N=4 then streams 0..3 correctly.
- start pulsed during an active N=6 packet → ignored; still exactly 6 beats and 1 done.

Source files
------------

// File: rtl/nmr_pkg.sv
// Shared definitions for the NMR buffer read-out path.
// State encoding and FIFO/credit sizing.
package nmr_pkg;
  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } state_t;

  localparam int FIFO_DEPTH = 4;
  localparam int CREDIT     = FIFO_DEPTH;
endpackage

// File: rtl/nmr_stream_fifo.sv
// Small synchronous FIFO with first-word-fall-through head
// and an occupancy count.
module nmr_stream_fifo
  import nmr_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output logic [2:0]            count,
  output logic                  empty
);
  localparam int PW = $clog2(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign empty   = (count == 3'd0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (count != 3'(FIFO_DEPTH));
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/nmr_buffer_reader.sv
// Streams a captured sample buffer out of BRAM as one
// AXI4-Stream packet, credit-limited against a 4-deep FIFO.
module nmr_buffer_reader
  import nmr_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [31:0]           nb_of_sample,
  output logic                  bram_en,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  input  logic [DATA_WIDTH-1:0] bram_rdata,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  busy,
  output logic                  done,
  output logic                  clamped,
  output logic [31:0]           words_sent
);
  localparam logic [ADDR_WIDTH:0] MAX_N =
    {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [31:0] MAX_N32 = 32'(MAX_N);

  state_t                state;
  logic [ADDR_WIDTH:0]   n;
  logic [ADDR_WIDTH:0]   n_req;
  logic [ADDR_WIDTH:0]   addr_cnt;
  logic                  rd_valid;
  logic [2:0]            count;
  logic                  empty;
  logic                  pop;
  logic [3:0]            used;
  logic                  credit_ok;
  logic                  drained;
  logic                  too_big;

  nmr_stream_fifo #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (rd_valid),
    .din  (bram_rdata),
    .pop  (pop),
    .head (m_axis_tdata),
    .count(count),
    .empty(empty)
  );

  assign too_big       = nb_of_sample > MAX_N32;
  assign n_req         = too_big ? MAX_N
                                 : nb_of_sample[ADDR_WIDTH:0];
  assign m_axis_tvalid = !empty;
  assign pop           = m_axis_tvalid && m_axis_tready;
  assign m_axis_tlast  = m_axis_tvalid &&
                         (words_sent == 32'(n) - 32'd1);

  // Buffered plus outstanding reads must stay within FIFO depth.
  assign used      = {1'b0, count} + {3'b0, bram_en}
                   + {3'b0, rd_valid};
  assign credit_ok = used < 4'(CREDIT);
  assign drained   = !bram_en && !rd_valid &&
                     (empty || (count == 3'd1 && pop));

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      n          <= '0;
      addr_cnt   <= '0;
      bram_en    <= 1'b0;
      bram_addr  <= '0;
      rd_valid   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      clamped    <= 1'b0;
      words_sent <= '0;
    end else begin
      rd_valid <= bram_en;
      if (pop) words_sent <= words_sent + 32'd1;
      unique case (state)
        IDLE: begin
          done    <= 1'b0;
          bram_en <= 1'b0;
          if (start) begin
            n          <= n_req;
            clamped    <= too_big;
            words_sent <= '0;
            busy       <= 1'b1;
            if (n_req == '0) begin
              state <= DONE;
            end else begin
              state     <= READ;
              bram_en   <= 1'b1;
              bram_addr <= '0;
              addr_cnt  <= {{ADDR_WIDTH{1'b0}}, 1'b1};
            end
          end
        end
        READ: begin
          if (addr_cnt == n) begin
            bram_en <= 1'b0;
            state   <= DRAIN;
          end else if (credit_ok) begin
            bram_en   <= 1'b1;
            bram_addr <= addr_cnt[ADDR_WIDTH-1:0];
            addr_cnt  <= addr_cnt + 1'b1;
          end else begin
            bram_en <= 1'b0;
          end
        end
        DRAIN: begin
          if (drained) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        DONE: begin
          // Empty packets arrive here with done low and pulse it now.
          state <= IDLE;
          done  <= ~done;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_nmr_buffer_reader.sv
// Randomised bench for nmr_buffer_reader against a
// packet-level reference model.
module tb_nmr_buffer_reader;
  localparam int AW    = 8;
  localparam int DW    = 32;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [31:0]   nb;
  logic          bram_en;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_rdata;
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tready;
  logic          tlast;
  logic          busy;
  logic          done;
  logic          clamped;
  logic [31:0]   words_sent;

  always #5 clk = ~clk;

  nmr_buffer_reader #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .nb_of_sample (nb),
    .bram_en      (bram_en),
    .bram_addr    (bram_addr),
    .bram_rdata   (bram_rdata),
    .m_axis_tdata (tdata),
    .m_axis_tvalid(tvalid),
    .m_axis_tready(tready),
    .m_axis_tlast (tlast),
    .busy         (busy),
    .done         (done),
    .clamped      (clamped),
    .words_sent   (words_sent)
  );

  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) if (bram_en) bram_rdata <= mem[bram_addr];

  int tests = 0;
  int fails = 0;

  function automatic void check(string name, longint act,
                                longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // Packet-level model: expected beat k carries mem[k].
  bit active = 0;
  int neff, issued, beat, done_cnt;
  int mode = 0;
  int cyc = 0;
  logic [3:0] pat = 4'b1001;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    case (mode)
      0:       tready = 1'b1;
      1:       tready = pat[cyc % 4];
      default: tready = 1'($urandom_range(0, 1));
    endcase
  end

  always @(negedge clk) begin
    if (!rst && active) begin
      if (bram_en) begin
        check("bram_addr", longint'(bram_addr), issued);
        check("addr_in_range", issued < neff, 1);
        issued++;
      end
      if (tvalid) begin
        check("tvalid_in_packet", beat < neff, 1);
        check("tdata", longint'(tdata),
              longint'(mem[beat % DEPTH]));
        check("tlast", tlast, beat == neff - 1);
        check("words_sent_run", longint'(words_sent), beat);
        if (tready) beat++;
      end else begin
        check("tlast_idle", tlast, 0);
      end
      check("credit", (issued - beat) <= 4, 1);
      if (done) begin
        done_cnt++;
        check("done_after_last", beat, neff);
      end
    end
  end

  task automatic fill(input bit by_addr);
    for (int i = 0; i < DEPTH; i++)
      mem[i] = by_addr ? DW'(i) : $urandom;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_tvalid"}, tvalid, 0);
    check({tag, "_tlast"}, tlast, 0);
    check({tag, "_bram_en"}, bram_en, 0);
    check({tag, "_bram_addr"}, longint'(bram_addr), 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_clamped"}, clamped, 0);
    check({tag, "_words"}, longint'(words_sent), 0);
  endtask

  task automatic run_packet(input int n, input int md,
                            input bit timed, input bit inject);
    mode = md;
    @(posedge clk); #1;
    neff = (n > DEPTH) ? DEPTH : n;
    issued = 0; beat = 0; done_cnt = 0; active = 1;
    start = 1'b1;
    nb = 32'(n);
    @(posedge clk); #1;
    start = 1'b0;
    if (timed) begin
      @(negedge clk);
      check("t_busy_e0", busy, 1);
      check("t_bram_en_e0", bram_en, 1);
      check("t_addr_e0", longint'(bram_addr), 0);
      check("t_tvalid_e0", tvalid, 0);
      @(negedge clk);
      check("t_tvalid_e1", tvalid, 0);
      for (int k = 0; k < n; k++) begin
        @(negedge clk);
        check("t_beat_valid", tvalid, 1);
        check("t_beat_data", longint'(tdata), k);
      end
      @(negedge clk);
      check("t_done", done, 1);
      check("t_busy_low", busy, 0);
    end
    if (n == 0) begin
      @(negedge clk);
      check("z_busy", busy, 1);
      check("z_done_early", done, 0);
      @(negedge clk);
      check("z_done", done, 1);
      check("z_busy_low", busy, 0);
    end
    for (int c = 0; c < 4000 && done_cnt == 0; c++) begin
      @(posedge clk); #1;
      start = inject && (c == 3);
      if (start) nb = 32'd3;
    end
    start = 1'b0;
    if (done_cnt == 0) check("timeout_done", 0, 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("beats", beat, neff);
    check("issued", issued, neff);
    check("done_pulses", done_cnt, 1);
    check("words_sent", longint'(words_sent), neff);
    check("busy_end", busy, 0);
    check("tvalid_end", tvalid, 0);
    check("clamped", clamped, n > DEPTH);
    active = 0;
  endtask

  task automatic reset_mid_packet();
    mode = 0;
    fill(0);
    @(posedge clk); #1;
    neff = 10; issued = 0; beat = 0; done_cnt = 0; active = 1;
    start = 1'b1;
    nb = 32'd10;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 100 && beat < 3; c++) @(posedge clk);
    check("reset_reach_beat3", beat >= 3, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    active = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_zero("midrst");
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    nb = '0;
    tready = 1'b1;
    fill(1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    run_packet(8, 0, 1, 0);
    fill(0);
    run_packet(16, 1, 0, 0);
    run_packet(0, 0, 0, 0);
    fill(0);
    run_packet(DEPTH + 5, 0, 0, 0);
    run_packet(3, 2, 0, 0);
    reset_mid_packet();
    run_packet(4, 0, 0, 0);
    fill(0);
    run_packet(6, 2, 0, 1);
    run_packet(1, 1, 0, 0);
    run_packet(DEPTH, 2, 0, 0);
    for (int i = 0; i < 6; i++) begin
      fill(0);
      run_packet(int'($urandom_range(1, 40)), 2, 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
